// File: rtl/ir_pkg.sv
// Definitions shared by the IR packet transmitter and decoder:
// nominal burst lengths, tick divider, FSM states and field indices.
package ir_pkg;

   localparam int TICK_DIV_NOM = 2667;

   localparam logic [7:0] NOM_START = 8'd88;
   localparam logic [7:0] NOM_SEL   = 8'd22;
   localparam logic [7:0] NOM_GAP   = 8'd40;
   localparam logic [7:0] NOM_ONE   = 8'd44;
   localparam logic [7:0] NOM_ZERO  = 8'd22;

   localparam logic [2:0] F_START = 3'd0;
   localparam logic [2:0] F_SEL   = 3'd1;
   localparam logic [2:0] F_BIT3  = 3'd2;
   localparam logic [2:0] F_BIT0  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST,
      S_GAP,
      S_DRAIN
   } ir_state_t;

   function automatic logic in_win(
      input logic [7:0] v,
      input logic [7:0] lo,
      input logic [7:0] hi
   );
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Carrier-period prescaler and saturating length counter, both
// cleared on every envelope edge.
module ir_tick_gen
   import ir_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_NOM
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   output logic       tick,
   output logic [7:0] length
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;
   logic [7:0]    len_q;

   assign tick = (cnt == LAST);

   // length includes a period completing in the current cycle, so an
   // edge after exactly N periods reads N
   assign length = (tick && len_q != 8'hFF) ? len_q + 8'd1 : len_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt   <= '0;
         len_q <= '0;
      end else if (tick) begin
         cnt   <= '0;
         len_q <= length;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ir_packet_decoder.sv
// Decodes start/select/4-bit command IR packets from the demodulated
// envelope, with framing checks and a one-cycle valid/error strobe.
module ir_packet_decoder
   import ir_pkg::*;
#(
   parameter int         TICK_DIV     = TICK_DIV_NOM,
   parameter logic [7:0] START_MIN    = 8'd80,
   parameter logic [7:0] START_MAX    = 8'd96,
   parameter logic [7:0] SEL_MIN      = 8'd18,
   parameter logic [7:0] SEL_MAX      = 8'd26,
   parameter logic [7:0] DEASSERT_MIN = 8'd18,
   parameter logic [7:0] DEASSERT_MAX = 8'd28,
   parameter logic [7:0] ASSERT_MIN   = 8'd38,
   parameter logic [7:0] ASSERT_MAX   = 8'd50,
   parameter logic [7:0] GAP_MIN      = 8'd34,
   parameter logic [7:0] GAP_MAX      = 8'd46
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       IR_IN,
   output logic [3:0] COMMAND,
   output logic       CMD_VALID,
   output logic       ERROR,
   output logic       BUSY
);

   logic       s1, s2, s3;
   logic       rise, fall;
   logic       tick;
   logic [7:0] length;
   ir_state_t  state;
   logic [2:0] f;
   logic [2:0] shreg;
   logic       ok, bit_val;
   logic [7:0] burst_max;

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;
   assign BUSY = (state != S_IDLE);

   ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (CLK),
      .reset  (RESET),
      .clr    (rise | fall),
      .tick   (tick),
      .length (length)
   );

   always_comb begin
      ok        = 1'b0;
      bit_val   = 1'b0;
      burst_max = (f == F_START) ? START_MAX : ASSERT_MAX;
      if (f == F_START) begin
         ok = in_win(length, START_MIN, START_MAX);
      end else if (f == F_SEL) begin
         ok = in_win(length, SEL_MIN, SEL_MAX);
      end else if (in_win(length, ASSERT_MIN, ASSERT_MAX)) begin
         ok      = 1'b1;
         bit_val = 1'b1;
      end else if (in_win(length, DEASSERT_MIN, DEASSERT_MAX)) begin
         ok = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         state     <= S_IDLE;
         f         <= F_START;
         shreg     <= '0;
         COMMAND   <= '0;
         CMD_VALID <= 1'b0;
         ERROR     <= 1'b0;
      end else begin
         s1        <= IR_IN;
         s2        <= s1;
         s3        <= s2;
         CMD_VALID <= 1'b0;
         ERROR     <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (rise) begin
                  state <= S_BURST;
                  f     <= F_START;
               end
            end
            S_BURST: begin
               if (fall) begin
                  if (!ok) begin
                     ERROR <= 1'b1;
                     state <= S_IDLE;
                  end else if (f == F_BIT0) begin
                     COMMAND   <= {shreg, bit_val};
                     CMD_VALID <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     if (f >= F_BIT3)
                        shreg <= {shreg[1:0], bit_val};
                     f     <= f + 3'd1;
                     state <= S_GAP;
                  end
               end else if (tick && length > burst_max) begin
                  // stuck-high envelope: report once, then wait it out
                  ERROR <= 1'b1;
                  state <= S_DRAIN;
               end
            end
            S_GAP: begin
               if (rise) begin
                  if (length < GAP_MIN) begin
                     // too-short gap: treat this burst as a new start
                     ERROR <= 1'b1;
                     f     <= F_START;
                     state <= S_BURST;
                  end else if (length <= GAP_MAX) begin
                     state <= S_BURST;
                  end else begin
                     ERROR <= 1'b1;
                     state <= S_IDLE;
                  end
               end else if (tick && length > GAP_MAX) begin
                  ERROR <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (fall)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
